fft_addr_ctrl: RTL and testbench

//   Sequencer for the in-place, memory-based radix-2 DIF FFT (N=32, Q2.14 twiddles).
//   Per stage and butterfly it generates the ping/pong RAM read addresses (a, b)
//   and the twiddle ROM index into twiddle_pkg::TWIDDLE_REAL/IMAG[0:15].
//   It also drives write-back enables/addresses delayed to match butterfly latency,
//   and holds off the next stage until the previous stage's writes have landed.

---
 rtl/fft_addr_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fft_addr_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIF FFT: read addresses, twiddle
// index and latency-matched write-back addresses, with a flush gap between stages.
module fft_addr_ctrl #(
   parameter int N          = 32,
   parameter int LOG2N      = 5,
   parameter int ADDR_W     = 5,
   parameter int TW_W       = 4,
   parameter int BF_LATENCY = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(LOG2N)-1:0] stage,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr_a,
   output logic [ADDR_W-1:0]        rd_addr_b,
   output logic [TW_W-1:0]          tw_idx,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr_a,
   output logic [ADDR_W-1:0]        wr_addr_b
);

   localparam int SW = $clog2(LOG2N);
   localparam int CW = $clog2(BF_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [TW_W-1:0] b_q, b_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   stg_q, stg_d;

   logic              rd_en_d, busy_d, done_d;
   logic [SW-1:0]     stage_d;
   logic [ADDR_W-1:0] rd_a_d, rd_b_d;
   logic [TW_W-1:0]   tw_d;

   logic              rd_en_q, busy_q, done_q;
   logic [SW-1:0]     stage_q;
   logic [ADDR_W-1:0] rd_a_q, rd_b_q;
   logic [TW_W-1:0]   tw_q;

   logic [BF_LATENCY-1:0] wen_p;
   logic [ADDR_W-1:0]     wa_p [BF_LATENCY];
   logic [ADDR_W-1:0]     wb_p [BF_LATENCY];

   int unsigned s_w, b_w, span_w, j_w, g_w, a_w;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         b_q     <= '0;
         cnt_q   <= '0;
         stg_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         stg_q   <= stg_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      stg_d   = stg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               b_d     = '0;
               cnt_d   = '0;
               stg_d   = '0;
            end
         end
         S_RUN: begin
            if (b_q == TW_W'(N / 2 - 1)) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end else begin
               b_d = b_q + 1'b1;
            end
         end
         S_FLUSH: begin
            if (cnt_q == CW'(BF_LATENCY - 1)) begin
               cnt_d = '0;
               if (stg_q == SW'(LOG2N - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  stg_d   = stg_q + 1'b1;
                  b_d     = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            stg_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: butterfly b of stage s pairs a = g*2*span + j with a + span
   always_comb begin
      s_w    = 32'(stg_q);
      b_w    = 32'(b_q);
      span_w = N >> (s_w + 1);
      j_w    = b_w & (span_w - 1);
      g_w    = b_w >> (LOG2N - 1 - s_w);
      a_w    = g_w * 2 * span_w + j_w;

      rd_en_d = (state_q == S_RUN);
      busy_d  = (state_q == S_RUN) || (state_q == S_FLUSH);
      done_d  = (state_q == S_DONE);
      stage_d = busy_d ? stg_q : '0;
      rd_a_d  = '0;
      rd_b_d  = '0;
      tw_d    = '0;
      if (rd_en_d) begin
         rd_a_d = ADDR_W'(a_w);
         rd_b_d = ADDR_W'(a_w + span_w);
         tw_d   = TW_W'(j_w << s_w);
      end
   end

   // Read-side output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         stage_q <= '0;
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         tw_q    <= '0;
      end else begin
         rd_en_q <= rd_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         stage_q <= stage_d;
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         tw_q    <= tw_d;
      end
   end

   // Write-back delay line, cleared on reset so no partial writes survive
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wen_p <= '0;
         for (int i = 0; i < BF_LATENCY; i++) begin
            wa_p[i] <= '0;
            wb_p[i] <= '0;
         end
      end else begin
         wen_p[0] <= rd_en_q;
         wa_p[0]  <= rd_a_q;
         wb_p[0]  <= rd_b_q;
         for (int i = 1; i < BF_LATENCY; i++) begin
            wen_p[i] <= wen_p[i-1];
            wa_p[i]  <= wa_p[i-1];
            wb_p[i]  <= wb_p[i-1];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign stage     = stage_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_a_q;
   assign rd_addr_b = rd_b_q;
   assign tw_idx    = tw_q;
   assign wr_en     = wen_p[BF_LATENCY-1];
   assign wr_addr_a = wa_p[BF_LATENCY-1];
   assign wr_addr_b = wb_p[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Scoreboard bench for fft_addr_ctrl: each accepted start queues the full expected
// read, write and done schedule, which a negedge monitor pops and compares.
module tb_fft_addr_ctrl;

   localparam int N      = 32;
   localparam int LOG2N  = 5;
   localparam int ADDR_W = 5;
   localparam int TW_W   = 4;
   localparam int LAT    = 3;
   localparam int RUN_LEN = 1 + LOG2N * (N / 2 + LAT);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              busy, done, rd_en, wr_en;
   logic [2:0]        stage;
   logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [TW_W-1:0]   tw_idx;

   typedef struct {
      int cyc;
      int a;
      int b;
      int tw;
      int st;
   } exp_t;

   exp_t rdq[$];
   exp_t wrq[$];
   int   doneq[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_rd   = 0;
   int n_wr   = 0;
   int t0;

   fft_addr_ctrl #(
      .N(N), .LOG2N(LOG2N), .ADDR_W(ADDR_W), .TW_W(TW_W), .BF_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_idx(tw_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected schedule: stage s, groups of 2*span points, butterflies in order.
   task automatic push_run(input int ts);
      exp_t e;
      int   span, k;
      for (int s = 0; s < LOG2N; s++) begin
         span = N >> (s + 1);
         k = 0;
         for (int g = 0; g < (N / 2) / span; g++) begin
            for (int j = 0; j < span; j++) begin
               e.cyc = ts + 1 + s * (N / 2 + LAT) + k;
               e.a   = g * 2 * span + j;
               e.b   = e.a + span;
               e.tw  = j << s;
               e.st  = s;
               rdq.push_back(e);
               e.cyc = e.cyc + LAT;
               wrq.push_back(e);
               k++;
            end
         end
      end
      doneq.push_back(ts + RUN_LEN);
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_rd_en"}, rd_en, 0);
      check_val({tag, "_wr_en"}, wr_en, 0);
      check_val({tag, "_stage"}, stage, 0);
      check_val({tag, "_rd_a"}, rd_addr_a, 0);
      check_val({tag, "_rd_b"}, rd_addr_b, 0);
      check_val({tag, "_wr_a"}, wr_addr_a, 0);
      check_val({tag, "_wr_b"}, wr_addr_b, 0);
      check_val({tag, "_tw"}, tw_idx, 0);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_drained(input string tag, input int runs);
      check_val({tag, "_rdq_left"}, rdq.size(), 0);
      check_val({tag, "_wrq_left"}, wrq.size(), 0);
      check_val({tag, "_doneq_left"}, doneq.size(), 0);
      check_val({tag, "_n_rd"}, n_rd, runs * LOG2N * N / 2);
      check_val({tag, "_n_wr"}, n_wr, runs * LOG2N * N / 2);
      check_val({tag, "_busy_end"}, busy, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   dc;
      if (rd_en) begin
         n_rd++;
         if (rdq.size() == 0) begin
            check_val("rd_unexpected", 1, 0);
         end else begin
            e = rdq.pop_front();
            check_val("rd_cycle", cyc, e.cyc);
            check_val("rd_addr_a", rd_addr_a, e.a);
            check_val("rd_addr_b", rd_addr_b, e.b);
            check_val("tw_idx", tw_idx, e.tw);
            check_val("rd_stage", stage, e.st);
            check_val("rd_busy", busy, 1);
         end
      end
      if (wr_en) begin
         n_wr++;
         if (wrq.size() == 0) begin
            check_val("wr_unexpected", 1, 0);
         end else begin
            e = wrq.pop_front();
            check_val("wr_cycle", cyc, e.cyc);
            check_val("wr_addr_a", wr_addr_a, e.a);
            check_val("wr_addr_b", wr_addr_b, e.b);
         end
      end
      if (done) begin
         if (doneq.size() == 0) begin
            check_val("done_unexpected", 1, 0);
         end else begin
            dc = doneq.pop_front();
            check_val("done_cycle", cyc, dc);
            check_val("busy_at_done", busy, 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single run with a stray start pulse in stage 1
      n_rd = 0; n_wr = 0;
      start = 1'b1;
      t0 = cyc + 1;
      push_run(t0);
      @(negedge clk);
      start = 1'b0;
      check_val("busy_at_t0", busy, 0);
      @(negedge clk);
      check_val("busy_at_t0p1", busy, 1);
      wait_until(t0 + 30);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(t0 + RUN_LEN - 1);
      check_val("busy_before_done", busy, 1);
      wait_until(t0 + RUN_LEN + 6);
      check_drained("run1", 1);
      check_idle("after_run1");

      // Start held high: second accept follows the DONE cycle
      n_rd = 0; n_wr = 0;
      start = 1'b1;
      t0 = cyc + 1;
      push_run(t0);
      push_run(t0 + RUN_LEN + 1);
      wait_until(t0 + RUN_LEN + 1);
      start = 1'b0;
      wait_until(t0 + 2 * (RUN_LEN + 1) + 6);
      check_drained("b2b", 2);

      // Reset in the middle of stage 2, then a clean run
      n_rd = 0; n_wr = 0;
      start = 1'b1;
      t0 = cyc + 1;
      push_run(t0);
      @(negedge clk);
      start = 1'b0;
      wait_until(t0 + 45);
      check_val("stage_before_rst", stage, 2);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle("midrst");
      rdq.delete();
      wrq.delete();
      doneq.delete();
      rst_n = 1'b1;
      n_rd = 0; n_wr = 0;
      repeat (10) @(negedge clk);
      check_val("post_rst_quiet_rd", n_rd, 0);
      check_val("post_rst_quiet_wr", n_wr, 0);
      start = 1'b1;
      t0 = cyc + 1;
      push_run(t0);
      @(negedge clk);
      start = 1'b0;
      wait_until(t0 + RUN_LEN + 6);
      check_drained("after_rst", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
